decim_out_fifo: RTL and testbench

- Downstream consumer of the systolic filter's rounded output: 18-bit samples qualified by a single-cycle new-data strobe.
- Keeps every DecimFactor-th sample, buffers kept samples in a small FIFO, and presents them to the next stage over a valid/ready handshake.
- Reports fill level and a sticky overflow flag so that back-pressure loss is visible to control logic.

---
 rtl/decim_out_fifo_pkg.sv | 19 +
 rtl/decim_out_fifo_sync_fifo_fwft.sv | 63 ++++++
 rtl/decim_out_fifo.sv | 71 +++++++
 tb/tb_decim_out_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/decim_out_fifo_pkg.sv
// Shared constants and types for the decimating output FIFO.
package decim_out_fifo_pkg;

    // Sample width shared with the filter and rounding stages.
    localparam int SAMPLE_W  = 18;
    localparam int MAX_DECIM = 256;

    // Keep/drop decision for one strobed sample.
    typedef struct packed {
        logic kept;
        logic drop;
    } keep_s;

    // Width of a 0..f-1 counter; at least one bit so f=1 still has a register.
    function automatic int phase_w(input int f);
        return (f > 1) ? $clog2(f) : 1;
    endfunction

endpackage

// File: rtl/decim_out_fifo_sync_fifo_fwft.sv
// First-word-fall-through FIFO: distributed RAM, async read, sync write.
module sync_fifo_fwft #(
    parameter int DataWidth = 18,
    parameter int AddrWidth = 4
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic                 Push_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 Ready_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 Valid_o,
    output logic [AddrWidth:0]   Level_o,
    output logic                 PushAcc_o
);
    localparam int Depth = 2 ** AddrWidth;

    logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrWidth:0]   level_q, level_d;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 full, pop;

    assign full      = (level_q == (AddrWidth+1)'(Depth));
    assign pop       = Valid_o & Ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign PushAcc_o = Push_i & (~full | pop);

    // Level tracks push/pop; simultaneous push+pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({PushAcc_o, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (PushAcc_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage array has no reset so it maps onto distributed RAM.
    always_ff @(posedge Clk_i) begin
        if (PushAcc_o) mem_q[wr_ptr_q] <= Data_i;
    end

    // Head of FIFO is forced to zero while empty.
    always_comb begin
        Valid_o = (level_q != '0);
        Data_o  = Valid_o ? mem_q[rd_ptr_q] : '0;
        Level_o = level_q;
    end

endmodule

// File: rtl/decim_out_fifo.sv
// Decimator front end: keeps every DecimFactor-th strobed sample and queues it.
module decim_out_fifo
    import decim_out_fifo_pkg::*;
#(
    parameter int DataWidth   = SAMPLE_W,
    parameter int DecimFactor = 4,
    parameter int AddrWidth   = 4
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 DataNd_i,
    input  logic                 OvfClr_i,
    input  logic                 DataReady_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 DataValid_o,
    output logic [AddrWidth:0]   Level_o,
    output logic                 Overflow_o
);
    localparam int PhW = phase_w(DecimFactor);

    logic [PhW-1:0] phase_q, phase_d;
    logic           ovf_q, ovf_d;
    logic           push_acc;
    keep_s          keep;

    // Drops still advance the phase, so the decimation grid never slips.
    always_comb begin
        phase_d = phase_q;
        if (DataNd_i)
            phase_d = (phase_q == PhW'(DecimFactor - 1)) ? '0 : phase_q + 1'b1;
    end

    // Keep decision and drop detection; a new drop beats a clear.
    always_comb begin
        keep.kept = DataNd_i & (phase_q == '0);
        keep.drop = keep.kept & ~push_acc;
        ovf_d     = ovf_q;
        if (OvfClr_i)  ovf_d = 1'b0;
        if (keep.drop) ovf_d = 1'b1;
    end

    // Phase counter and sticky overflow registers.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Overflow_o = ovf_q;

    sync_fifo_fwft #(
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth)
    ) u_fifo (
        .Clk_i    (Clk_i),
        .Rst_i    (Rst_i),
        .Push_i   (keep.kept),
        .Data_i   (Data_i),
        .Ready_i  (DataReady_i),
        .Data_o   (Data_o),
        .Valid_o  (DataValid_o),
        .Level_o  (Level_o),
        .PushAcc_o(push_acc)
    );

endmodule

// File: tb/tb_decim_out_fifo.sv
// Bench: three configurations driven in parallel against a queue-based model.
module tb_decim_out_fifo;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [17:0] din;
    logic        nd, clr;
    logic [2:0]  rdy;

    logic [17:0] dout [3];
    logic        vld  [3];
    logic        ovf  [3];
    logic [4:0]  lvl0;
    logic [2:0]  lvl1, lvl2;

    int n_vec = 0;
    int n_err = 0;

    // Model: per instance decimation factor, depth, phase, overflow, queue.
    int          DF  [3] = '{4, 1, 3};
    int          DEP [3] = '{16, 4, 4};
    int          ph  [3];
    bit          mov [3];
    logic [17:0] mq  [3][$];

    always #5 Clk = ~Clk;

    decim_out_fifo #(.DataWidth(18), .DecimFactor(4), .AddrWidth(4)) u0 (
        .Clk_i(Clk), .Rst_i(Rst), .Data_i(din), .DataNd_i(nd), .OvfClr_i(clr),
        .DataReady_i(rdy[0]), .Data_o(dout[0]), .DataValid_o(vld[0]),
        .Level_o(lvl0), .Overflow_o(ovf[0]));

    decim_out_fifo #(.DataWidth(18), .DecimFactor(1), .AddrWidth(2)) u1 (
        .Clk_i(Clk), .Rst_i(Rst), .Data_i(din), .DataNd_i(nd), .OvfClr_i(clr),
        .DataReady_i(rdy[1]), .Data_o(dout[1]), .DataValid_o(vld[1]),
        .Level_o(lvl1), .Overflow_o(ovf[1]));

    decim_out_fifo #(.DataWidth(18), .DecimFactor(3), .AddrWidth(2)) u2 (
        .Clk_i(Clk), .Rst_i(Rst), .Data_i(din), .DataNd_i(nd), .OvfClr_i(clr),
        .DataReady_i(rdy[2]), .Data_o(dout[2]), .DataValid_o(vld[2]),
        .Level_o(lvl2), .Overflow_o(ovf[2]));

    function automatic int lv(input int k);
        case (k)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            default: return int'(lvl2);
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 3; k++) begin
            ph[k]  = 0;
            mov[k] = 1'b0;
            mq[k].delete();
        end
    endtask

    // One clock edge of the spec's behaviour, phrased as queue operations.
    task automatic mstep(input int k);
        bit kept, pop;
        kept = nd && (ph[k] == 0);
        pop  = rdy[k] && (mq[k].size() != 0);
        if (nd) ph[k] = (ph[k] + 1) % DF[k];
        if (pop) void'(mq[k].pop_front());
        if (clr) mov[k] = 1'b0;
        if (kept) begin
            if (mq[k].size() < DEP[k]) mq[k].push_back(din);
            else                      mov[k] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_valid", k), int'(vld[k]), int'(mq[k].size() != 0));
            chk($sformatf("u%0d_data", k), int'(dout[k]),
                (mq[k].size() != 0) ? int'(mq[k][0]) : 0);
            chk($sformatf("u%0d_level", k), lv(k), mq[k].size());
            chk($sformatf("u%0d_ovf", k), int'(ovf[k]), int'(mov[k]));
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        for (int k = 0; k < 3; k++) begin
            if (Rst) mreset();
            else     mstep(k);
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic strobe(input logic [17:0] v);
        nd  = 1'b1;
        din = v;
        cyc();
        nd  = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic arst();
        #2;
        Rst = 1'b1;
        #1;
        mreset();
        check_all();
        chk("arst_u2_valid", int'(vld[2]), 0);
        chk("arst_u2_level", lv(2), 0);
        #2;
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        din = '0;
        nd  = 1'b0;
        clr = 1'b0;
        rdy = '0;
        mreset();
        #12;
        check_all();
        Rst = 1'b0;

        // Decimate by 4 with a always-ready consumer.
        rdy = 3'b111;
        for (int v = 1; v <= 12; v++) begin
            strobe(18'(v));
            chk("s1_u0_lvl_le1", int'(lv(0) <= 1), 1);
        end
        idle(2);
        chk("s1_u0_empty", lv(0), 0);

        // No decimation, stalled consumer, overflow on the fifth sample.
        arst();
        rdy = '0;
        for (int v = 1; v <= 6; v++) begin
            strobe(18'(v));
            if (v == 4) chk("s2_u1_ovf_before", int'(ovf[1]), 0);
            if (v == 5) chk("s2_u1_ovf_set", int'(ovf[1]), 1);
        end
        chk("s2_u1_level", lv(1), 4);
        chk("s2_u1_head", int'(dout[1]), 1);
        rdy[1] = 1'b1;
        idle(4);
        chk("s2_u1_drained", int'(vld[1]), 0);

        // Full FIFO accepts a push when popped on the same edge.
        arst();
        rdy = '0;
        for (int v = 1; v <= 4; v++) strobe(18'(v));
        rdy[1] = 1'b1;
        strobe(18'h1FFFF);
        chk("s3_u1_level", lv(1), 4);
        chk("s3_u1_ovf", int'(ovf[1]), 0);
        idle(3);
        chk("s3_u1_last", int'(dout[1]), 'h1FFFF);
        idle(2);

        // Decimate by 3 with irregular gaps between strobes.
        arst();
        rdy = '0;
        for (int v = 1; v <= 7; v++) begin
            strobe(18'(v));
            idle($urandom_range(1, 5));
        end
        chk("s4_u2_level", lv(2), 3);
        chk("s4_u2_head", int'(dout[2]), 1);
        rdy[2] = 1'b1;
        idle(1);
        chk("s4_u2_second", int'(dout[2]), 4);
        idle(3);

        // Clear coincident with a drop loses; a clean clear wins.
        arst();
        rdy = '0;
        for (int v = 1; v <= 5; v++) strobe(18'(v));
        chk("s5_u1_ovf", int'(ovf[1]), 1);
        clr = 1'b1;
        strobe(18'd6);
        clr = 1'b0;
        chk("s5_u1_ovf_setwins", int'(ovf[1]), 1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("s5_u1_ovf_clr", int'(ovf[1]), 0);

        // Async reset with three entries queued and phase at 2.
        arst();
        rdy = '0;
        for (int v = 1; v <= 8; v++) strobe(18'(v));
        chk("s6_u2_level", lv(2), 3);
        arst();
        strobe(18'h2AAAA);
        chk("s6_u2_kept", lv(2), 1);
        chk("s6_u2_data", int'(dout[2]), 'h2AAAA);

        // Random traffic: stall-heavy first half, drain-heavy second half.
        arst();
        for (int i = 0; i < 2000; i++) begin
            nd  = ($urandom % 3) != 0;
            din = 18'($urandom);
            clr = ($urandom % 16) == 0;
            for (int k = 0; k < 3; k++)
                rdy[k] = (i < 1000) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            if (($urandom % 250) == 0) arst();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
